// File: rtl/legv8_control_fsm_pkg.sv
// Shared encodings for the LEGv8 control unit: ALU function codes, PC-select codes,
// opcode constants, FSM state encodings, control-word layout and decode helpers.
package legv8_control_fsm_pkg;

   localparam logic [4:0] FS_AND   = 5'b00000;
   localparam logic [4:0] FS_OR    = 5'b00100;
   localparam logic [4:0] FS_ADD   = 5'b01000;
   localparam logic [4:0] FS_SUB   = 5'b01001;
   localparam logic [4:0] FS_XOR   = 5'b01100;
   localparam logic [4:0] FS_PASSA = 5'b10000;
   localparam logic [4:0] FS_PASSB = 5'b10100;

   localparam logic [1:0] PS_HOLD = 2'b00;
   localparam logic [1:0] PS_INC  = 2'b01;
   localparam logic [1:0] PS_REG  = 2'b10;
   localparam logic [1:0] PS_REL  = 2'b11;

   localparam logic [2:0] ST_FETCH = 3'd0;
   localparam logic [2:0] ST_EXEC  = 3'd1;
   localparam logic [2:0] ST_LOAD2 = 3'd2;
   localparam logic [2:0] ST_CBR2  = 3'd3;
   localparam logic [2:0] ST_HALT  = 3'd4;

   // R- and D-format opcodes live in IR[31:21]
   localparam logic [10:0] OP_ADD  = 11'h458;
   localparam logic [10:0] OP_ADDS = 11'h558;
   localparam logic [10:0] OP_SUB  = 11'h658;
   localparam logic [10:0] OP_SUBS = 11'h758;
   localparam logic [10:0] OP_AND  = 11'h450;
   localparam logic [10:0] OP_ANDS = 11'h750;
   localparam logic [10:0] OP_ORR  = 11'h550;
   localparam logic [10:0] OP_EOR  = 11'h650;
   localparam logic [10:0] OP_LDUR = 11'h7C2;
   localparam logic [10:0] OP_STUR = 11'h7C0;
   localparam logic [10:0] OP_BR   = 11'h6B0;

   // I-format opcodes live in IR[31:22]
   localparam logic [9:0] OP_ADDI = 10'h244;
   localparam logic [9:0] OP_SUBI = 10'h344;
   localparam logic [9:0] OP_ANDI = 10'h248;
   localparam logic [9:0] OP_ORRI = 10'h2C8;
   localparam logic [9:0] OP_EORI = 10'h348;

   localparam logic [8:0] OP_MOVZ  = 9'h1A5;
   localparam logic [7:0] OP_BCOND = 8'h54;
   localparam logic [7:0] OP_CBZ   = 8'hB4;
   localparam logic [7:0] OP_CBNZ  = 8'hB5;
   localparam logic [5:0] OP_B     = 6'h05;
   localparam logic [5:0] OP_BL    = 6'h25;

   typedef struct packed {
      logic       en_pc;
      logic       en_mem;
      logic       en_alu;
      logic       pc_sel;
      logic       b_sel;
      logic       sl;
      logic       wm;
      logic       wr;
      logic [1:0] ps;
      logic [4:0] fs;
      logic [4:0] sb;
      logic [4:0] sa;
      logic [4:0] da;
   } ctrl_t;

   typedef enum logic [3:0] {
      CLS_NONE,
      CLS_RTYPE,
      CLS_ITYPE,
      CLS_MOVZ,
      CLS_LDUR,
      CLS_STUR,
      CLS_B,
      CLS_BL,
      CLS_BR,
      CLS_BCOND,
      CLS_CBZ,
      CLS_CBNZ
   } iclass_t;

   // Opcode fields of different widths never alias, so the check order is arbitrary.
   function automatic iclass_t classify(input logic [31:0] ir);
      iclass_t cls;
      cls = CLS_NONE;
      case (ir[31:21])
         OP_ADD, OP_ADDS, OP_SUB, OP_SUBS,
         OP_AND, OP_ANDS, OP_ORR, OP_EOR: cls = CLS_RTYPE;
         OP_LDUR:                         cls = CLS_LDUR;
         OP_STUR:                         cls = CLS_STUR;
         OP_BR:                           cls = CLS_BR;
         default:                         cls = CLS_NONE;
      endcase
      if (cls == CLS_NONE) begin
         case (ir[31:22])
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI: cls = CLS_ITYPE;
            default:                                     cls = CLS_NONE;
         endcase
      end
      if (cls == CLS_NONE) begin
         if (ir[31:23] == OP_MOVZ)       cls = CLS_MOVZ;
         else if (ir[31:24] == OP_BCOND) cls = CLS_BCOND;
         else if (ir[31:24] == OP_CBZ)   cls = CLS_CBZ;
         else if (ir[31:24] == OP_CBNZ)  cls = CLS_CBNZ;
         else if (ir[31:26] == OP_B)     cls = CLS_B;
         else if (ir[31:26] == OP_BL)    cls = CLS_BL;
      end
      return cls;
   endfunction

   function automatic logic [4:0] r_fs(input logic [10:0] op);
      case (op)
         OP_ADD, OP_ADDS: r_fs = FS_ADD;
         OP_SUB, OP_SUBS: r_fs = FS_SUB;
         OP_AND, OP_ANDS: r_fs = FS_AND;
         OP_ORR:          r_fs = FS_OR;
         OP_EOR:          r_fs = FS_XOR;
         default:         r_fs = FS_ADD;
      endcase
   endfunction

   function automatic logic [4:0] i_fs(input logic [9:0] op);
      case (op)
         OP_ADDI: i_fs = FS_ADD;
         OP_SUBI: i_fs = FS_SUB;
         OP_ANDI: i_fs = FS_AND;
         OP_ORRI: i_fs = FS_OR;
         OP_EORI: i_fs = FS_XOR;
         default: i_fs = FS_ADD;
      endcase
   endfunction

   // Flag-setting forms are matched explicitly: ORR shares IR[29]=1 with the S forms.
   function automatic logic r_sets_flags(input logic [10:0] op);
      return (op == OP_ADDS) || (op == OP_SUBS) || (op == OP_ANDS);
   endfunction

endpackage

// File: rtl/legv8_cond_eval.sv
// B.cond evaluator: 4-bit condition code plus registered {V,C,N,Z} -> taken.
module legv8_cond_eval
   import legv8_control_fsm_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       taken
);

   logic v, c, n, z;
   logic base;

   assign v = flags[3];
   assign c = flags[2];
   assign n = flags[1];
   assign z = flags[0];

   // NOTE: every variable written in always_comb gets a default first, so no path leaves it holding its old value (a latch).
   always_comb begin
      base = 1'b0;
      case (cond[3:1])
         3'b000: base = z;
         3'b001: base = c;
         3'b010: base = n;
         3'b011: base = v;
         3'b100: base = c & ~z;
         3'b101: base = (n == v);
         3'b110: base = (n == v) & ~z;
         3'b111: base = 1'b1;
         default: base = 1'b0;
      endcase
   end

   // Odd codes invert their even partner; NV (1111) stays always-taken like AL.
   assign taken = (cond[0] && (cond != 4'hF)) ? ~base : base;

endmodule

// File: rtl/legv8_control_fsm.sv
// Multi-cycle LEGv8 control unit: latches the instruction, decodes it and sequences
// the datapath through FETCH / EXEC / LOAD2 / CBR2 / HALT.
module legv8_control_fsm
   import legv8_control_fsm_pkg::*;
#(
   parameter logic [4:0] LINK_REG = 5'd30
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic [4:0]  status,
   output logic [29:0] control_word,
   output logic [63:0] constant,
   output logic        halted
);

   logic [2:0]  state_q, state_d;
   logic [31:0] ir_q, ir_d;
   logic        cbr_zero_q, cbr_zero_d;

   iclass_t     cls;
   ctrl_t       ctrl;
   logic [63:0] const_val;
   logic        halt_val;
   logic        bcond_taken;
   logic        cbr_taken;

   logic [4:0]  rd, rn, rm;
   logic [63:0] imm9_sx, imm12_zx, imm16_sh, imm19_sx, imm26_sx;

   assign rd  = ir_q[4:0];
   assign rn  = ir_q[9:5];
   assign rm  = ir_q[20:16];
   assign cls = classify(ir_q);

   assign imm9_sx  = {{55{ir_q[20]}}, ir_q[20:12]};
   assign imm12_zx = {52'd0, ir_q[21:10]};
   assign imm16_sh = {48'd0, ir_q[20:5]} << {ir_q[22:21], 4'b0000};
   assign imm19_sx = {{45{ir_q[23]}}, ir_q[23:5]};
   assign imm26_sx = {{38{ir_q[25]}}, ir_q[25:0]};

   legv8_cond_eval u_cond_eval (
      .cond  (ir_q[3:0]),
      .flags (status[4:1]),
      .taken (bcond_taken)
   );

   // The CB decision uses the zero flag captured at the end of EXEC, never the live ALU zero.
   assign cbr_taken = (cls == CLS_CBNZ) ? ~cbr_zero_q : cbr_zero_q;

   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      cbr_zero_d = cbr_zero_q;
      ctrl       = '0;
      const_val  = '0;
      halt_val   = 1'b0;

      case (state_q)
         ST_FETCH: begin
            ir_d    = instruction;
            state_d = ST_EXEC;
         end

         ST_EXEC: begin
            state_d = ST_FETCH;
            case (cls)
               CLS_RTYPE: begin
                  ctrl.en_alu = 1'b1;
                  ctrl.wr     = 1'b1;
                  ctrl.ps     = PS_INC;
                  ctrl.fs     = r_fs(ir_q[31:21]);
                  ctrl.sl     = r_sets_flags(ir_q[31:21]);
                  ctrl.sa     = rn;
                  ctrl.sb     = rm;
                  ctrl.da     = rd;
               end
               CLS_ITYPE: begin
                  ctrl.en_alu = 1'b1;
                  ctrl.wr     = 1'b1;
                  ctrl.b_sel  = 1'b1;
                  ctrl.ps     = PS_INC;
                  ctrl.fs     = i_fs(ir_q[31:22]);
                  ctrl.sa     = rn;
                  ctrl.da     = rd;
                  const_val   = imm12_zx;
               end
               CLS_MOVZ: begin
                  ctrl.en_alu = 1'b1;
                  ctrl.wr     = 1'b1;
                  ctrl.b_sel  = 1'b1;
                  ctrl.ps     = PS_INC;
                  ctrl.fs     = FS_PASSB;
                  ctrl.da     = rd;
                  const_val   = imm16_sh;
               end
               CLS_LDUR: begin
                  ctrl.b_sel = 1'b1;
                  ctrl.fs    = FS_ADD;
                  ctrl.sa    = rn;
                  ctrl.ps    = PS_HOLD;
                  const_val  = imm9_sx;
                  state_d    = ST_LOAD2;
               end
               CLS_STUR: begin
                  ctrl.b_sel = 1'b1;
                  ctrl.fs    = FS_ADD;
                  ctrl.sa    = rn;
                  ctrl.sb    = rd;
                  ctrl.wm    = 1'b1;
                  ctrl.ps    = PS_INC;
                  const_val  = imm9_sx;
               end
               CLS_B: begin
                  ctrl.ps   = PS_REL;
                  const_val = imm26_sx;
               end
               CLS_BL: begin
                  ctrl.ps    = PS_REL;
                  ctrl.en_pc = 1'b1;
                  ctrl.wr    = 1'b1;
                  ctrl.da    = LINK_REG;
                  const_val  = imm26_sx;
               end
               CLS_BR: begin
                  ctrl.sa = rn;
                  ctrl.ps = PS_REG;
               end
               CLS_BCOND: begin
                  ctrl.ps   = bcond_taken ? PS_REL : PS_INC;
                  const_val = imm19_sx;
               end
               CLS_CBZ, CLS_CBNZ: begin
                  ctrl.sa    = rd;
                  ctrl.fs    = FS_PASSA;
                  ctrl.ps    = PS_HOLD;
                  cbr_zero_d = status[0];
                  state_d    = ST_CBR2;
               end
               default: state_d = ST_HALT;
            endcase
         end

         ST_LOAD2: begin
            // Address fields stay stable so the memory output remains valid for write-back.
            ctrl.b_sel  = 1'b1;
            ctrl.fs     = FS_ADD;
            ctrl.sa     = rn;
            ctrl.en_mem = 1'b1;
            ctrl.wr     = 1'b1;
            ctrl.da     = rd;
            ctrl.ps     = PS_INC;
            const_val   = imm9_sx;
            state_d     = ST_FETCH;
         end

         ST_CBR2: begin
            ctrl.ps   = cbr_taken ? PS_REL : PS_INC;
            const_val = imm19_sx;
            state_d   = ST_FETCH;
         end

         ST_HALT: halt_val = 1'b1;

         default: state_d = ST_FETCH;
      endcase

      // Reset masks the outputs in the same cycle so no partial write can complete.
      if (reset) begin
         ctrl      = '0;
         const_val = '0;
         halt_val  = 1'b0;
      end
   end

   assign control_word = ctrl;
   assign constant     = const_val;
   assign halted       = halt_val;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_FETCH;
         ir_q       <= '0;
         cbr_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         cbr_zero_q <= cbr_zero_d;
      end
   end

endmodule

// File: tb/tb_legv8_control_fsm.sv
// Scoreboard bench for legv8_control_fsm: expected per-cycle outputs are queued with the
// stimulus and compared on the falling edge as the FSM steps through each instruction.
module tb_legv8_control_fsm;
   import legv8_control_fsm_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instruction = '0;
   logic [4:0]  status = '0;
   logic [29:0] control_word;
   logic [63:0] constant;
   logic        halted;

   int total = 0;
   int bad   = 0;

   localparam logic [29:0] M_ALL  = 30'h3FFF_FFFF;
   localparam logic [29:0] M_EN   = 30'h3800_0000;
   localparam logic [29:0] M_BSEL = 30'h0200_0000;
   localparam logic [29:0] M_WM   = 30'h0080_0000;
   localparam logic [29:0] M_WR   = 30'h0040_0000;
   localparam logic [29:0] M_PS   = 30'h0030_0000;
   localparam logic [29:0] M_FS   = 30'h000F_8000;
   localparam logic [29:0] M_SB   = 30'h0000_7C00;
   localparam logic [29:0] M_SA   = 30'h0000_03E0;
   localparam logic [29:0] M_DA   = 30'h0000_001F;

   typedef struct packed {
      logic [29:0] mask;
      logic [29:0] cw;
      logic        chk_k;
      logic [63:0] k;
      logic        hlt;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];

   legv8_control_fsm #(.LINK_REG(5'd30)) dut (
      .clock        (clock),
      .reset        (reset),
      .instruction  (instruction),
      .status       (status),
      .control_word (control_word),
      .constant     (constant),
      .halted       (halted)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [29:0] mk_cw(input logic en_pc, input logic en_mem,
                                         input logic en_alu, input logic bsel, input logic sl,
                                         input logic wm, input logic wr, input logic [1:0] ps,
                                         input logic [4:0] fs, input logic [4:0] sb,
                                         input logic [4:0] sa, input logic [4:0] da);
      return {en_pc, en_mem, en_alu, 1'b0, bsel, sl, wm, wr, ps, fs, sb, sa, da};
   endfunction

   task automatic push_exp(input string tag, input logic [29:0] mask, input logic [29:0] cw,
                           input logic chk_k, input logic [63:0] k, input logic hlt);
      exp_t e;
      e.mask  = mask;
      e.cw    = cw & mask;
      e.chk_k = chk_k;
      e.k     = k;
      e.hlt   = hlt;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic push_idle(input string tag);
      push_exp(tag, M_ALL, 30'd0, 1'b1, 64'd0, 1'b0);
   endtask

   // Monitor: one queued expectation per clock, sampled on the falling edge.
   task automatic drain();
      exp_t  e;
      string tag;
      int    nbus;
      while (exp_q.size() > 0) begin
         @(negedge clock);
         e   = exp_q.pop_front();
         tag = tag_q.pop_front();
         total++;
         if ((control_word & e.mask) !== e.cw) begin
            bad++;
            $display("FAIL %s control_word: got=%h want=%h (mask %h)", tag,
                     control_word & e.mask, e.cw, e.mask);
         end
         if (e.chk_k) begin
            total++;
            if (constant !== e.k) begin
               bad++;
               $display("FAIL %s constant: got=%h want=%h", tag, constant, e.k);
            end
         end
         total++;
         if (halted !== e.hlt) begin
            bad++;
            $display("FAIL %s halted: got=%b want=%b", tag, halted, e.hlt);
         end
         nbus = int'(control_word[29]) + int'(control_word[28]) + int'(control_word[27]);
         total++;
         if (nbus > 1) begin
            bad++;
            $display("FAIL %s bus_rule: enables=%0d want<=1", tag, nbus);
         end
         @(posedge clock);
         #1;
      end
   endtask

   task automatic run2(input string tag, input logic [31:0] instr, input logic [4:0] st,
                       input logic [29:0] mask, input logic [29:0] cw, input logic chk_k,
                       input logic [63:0] k);
      instruction = instr;
      status      = st;
      push_idle({tag, "_fetch"});
      push_exp({tag, "_exec"}, mask, cw, chk_k, k, 1'b0);
      drain();
   endtask

   task automatic test_reset();
      push_idle("rst_hold");
      drain();
      reset = 1'b0;
      instruction = 32'h8B02_0023;
      push_idle("rst_fetch");
      drain();
      // Now in EXEC of the ADD: reset for two cycles must blank everything.
      reset = 1'b1;
      push_idle("rst_mid_exec0");
      drain();
      push_idle("rst_mid_exec1");
      drain();
      reset = 1'b0;
      push_idle("rst_release_fetch");
      push_exp("rst_release_exec", M_ALL,
               mk_cw(0, 0, 1, 0, 0, 0, 1, 2'b01, FS_ADD, 5'd2, 5'd1, 5'd3), 1'b0, 64'd0, 1'b0);
      drain();
   endtask

   task automatic test_rtype();
      run2("add", 32'h8B02_0023, 5'd0, M_ALL,
           mk_cw(0, 0, 1, 0, 0, 0, 1, 2'b01, FS_ADD, 5'd2, 5'd1, 5'd3), 1'b0, 64'd0);
      run2("subs", {11'h758, 5'd6, 6'd0, 5'd5, 5'd7}, 5'd0, M_ALL,
           mk_cw(0, 0, 1, 0, 1, 0, 1, 2'b01, FS_SUB, 5'd6, 5'd5, 5'd7), 1'b0, 64'd0);
      run2("orr", {11'h550, 5'd10, 6'd0, 5'd8, 5'd9}, 5'd0, M_ALL,
           mk_cw(0, 0, 1, 0, 0, 0, 1, 2'b01, FS_OR, 5'd10, 5'd8, 5'd9), 1'b0, 64'd0);
   endtask

   task automatic test_itype();
      run2("addi", {10'h244, 12'hFFF, 5'd1, 5'd2}, 5'd0, M_ALL & ~M_SB,
           mk_cw(0, 0, 1, 1, 0, 0, 1, 2'b01, FS_ADD, 5'd0, 5'd1, 5'd2), 1'b1, 64'h0FFF);
      run2("andi", {10'h248, 12'd1, 5'd6, 5'd5}, 5'd0, M_ALL & ~M_SB,
           mk_cw(0, 0, 1, 1, 0, 0, 1, 2'b01, FS_AND, 5'd0, 5'd6, 5'd5), 1'b1, 64'd1);
      run2("movz", {9'h1A5, 2'd3, 16'hBEEF, 5'd4}, 5'd0, M_ALL & ~(M_SA | M_SB),
           mk_cw(0, 0, 1, 1, 0, 0, 1, 2'b01, FS_PASSB, 5'd0, 5'd0, 5'd4), 1'b1,
           64'hBEEF_0000_0000_0000);
   endtask

   task automatic test_memory();
      instruction = 32'hF840_8025;
      status      = 5'd0;
      push_idle("ldur_fetch");
      push_exp("ldur_exec", M_EN | M_BSEL | M_WM | M_WR | M_PS | M_FS | M_SA,
               mk_cw(0, 0, 0, 1, 0, 0, 0, 2'b00, FS_ADD, 5'd0, 5'd1, 5'd0), 1'b1, 64'd8, 1'b0);
      push_exp("ldur_load2", M_EN | M_WM | M_WR | M_PS | M_DA,
               mk_cw(0, 1, 0, 0, 0, 0, 1, 2'b01, 5'd0, 5'd0, 5'd0, 5'd5), 1'b0, 64'd0, 1'b0);
      drain();
      run2("stur", {11'h7C0, 9'h1FF, 2'b00, 5'd2, 5'd6}, 5'd0, M_ALL & ~M_DA,
           mk_cw(0, 0, 0, 1, 0, 1, 0, 2'b01, FS_ADD, 5'd6, 5'd2, 5'd0), 1'b1, {64{1'b1}});
   endtask

   // status[0] is flipped during CBR2 to show the decision uses the value captured in EXEC.
   task automatic cb_case(input string tag, input logic [31:0] instr, input logic zero_in,
                          input logic [1:0] ps_want);
      instruction = instr;
      status      = {4'b0000, zero_in};
      push_idle({tag, "_fetch"});
      push_exp({tag, "_exec"}, M_EN | M_WM | M_WR | M_PS | M_FS | M_SA,
               mk_cw(0, 0, 0, 0, 0, 0, 0, 2'b00, FS_PASSA, 5'd0, 5'd4, 5'd0), 1'b0, 64'd0, 1'b0);
      drain();
      status = {4'b0000, ~zero_in};
      push_exp({tag, "_cbr2"}, M_EN | M_WM | M_WR | M_PS,
               mk_cw(0, 0, 0, 0, 0, 0, 0, ps_want, 5'd0, 5'd0, 5'd0, 5'd0), 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      drain();
   endtask

   task automatic test_cbz();
      cb_case("cbz_taken",  32'hB4FF_FFC4, 1'b1, 2'b11);
      cb_case("cbz_not",    32'hB4FF_FFC4, 1'b0, 2'b01);
      cb_case("cbnz_taken", 32'hB5FF_FFC4, 1'b0, 2'b11);
      cb_case("cbnz_not",   32'hB5FF_FFC4, 1'b1, 2'b01);
   endtask

   task automatic test_bcond();
      logic [29:0] cw_taken;
      logic [29:0] cw_not;
      cw_taken = mk_cw(0, 0, 0, 0, 0, 0, 0, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0);
      cw_not   = mk_cw(0, 0, 0, 0, 0, 0, 0, 2'b01, 5'd0, 5'd0, 5'd0, 5'd0);
      run2("beq_taken", 32'h5400_0060, 5'b00010, M_ALL, cw_taken, 1'b1, 64'd3);
      run2("beq_not",   32'h5400_0060, 5'b00001, M_ALL, cw_not,   1'b1, 64'd3);
      run2("bgt_taken", {8'h54, 19'h7FFFF, 1'b0, 4'hC}, 5'b10100, M_ALL, cw_taken, 1'b1,
           {64{1'b1}});
      run2("bgt_not",   {8'h54, 19'h7FFFF, 1'b0, 4'hC}, 5'b10000, M_ALL, cw_not, 1'b1,
           {64{1'b1}});
      run2("bnv_taken", {8'h54, 19'd1, 1'b0, 4'hF}, 5'b00000, M_ALL, cw_taken, 1'b1, 64'd1);
   endtask

   task automatic test_branch();
      run2("b", {6'h05, 26'd5}, 5'd0, M_ALL,
           mk_cw(0, 0, 0, 0, 0, 0, 0, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0), 1'b1, 64'd5);
      run2("bl", {6'h25, 26'h3FF_FFFC}, 5'd0, M_ALL,
           mk_cw(1, 0, 0, 0, 0, 0, 1, 2'b11, 5'd0, 5'd0, 5'd0, 5'd30), 1'b1,
           64'hFFFF_FFFF_FFFF_FFFC);
      run2("br", {11'h6B0, 5'd31, 6'd0, 5'd17, 5'd0}, 5'd0, M_ALL,
           mk_cw(0, 0, 0, 0, 0, 0, 0, 2'b10, 5'd0, 5'd0, 5'd17, 5'd0), 1'b0, 64'd0);
   endtask

   task automatic test_halt();
      run2("halt_entry", 32'h0000_0000, 5'd0, M_ALL, 30'd0, 1'b0, 64'd0);
      instruction = 32'h8B02_0023;
      for (int i = 0; i < 10; i++) push_exp($sformatf("halt_%0d", i), M_ALL, 30'd0, 1'b0, 64'd0, 1'b1);
      drain();
      reset = 1'b1;
      push_idle("halt_reset");
      drain();
      reset = 1'b0;
      push_idle("halt_post_fetch");
      push_exp("halt_post_exec", M_ALL,
               mk_cw(0, 0, 1, 0, 0, 0, 1, 2'b01, FS_ADD, 5'd2, 5'd1, 5'd3), 1'b0, 64'd0, 1'b0);
      drain();
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      test_reset();
      test_rtype();
      test_itype();
      test_memory();
      test_cbz();
      test_bcond();
      test_branch();
      test_halt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
